// File: rtl/dmem_mmio.sv
// rtl/dmem_mmio.sv - data RAM plus MMIO UART TX FIFO, cycle counter and tohost halt
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   dmem_addr/wdata/wstrb/we/re    core LSU request (byte address, lane-aligned data)
//   dmem_rdata                     combinational read data
//   uart_tx_valid/data/ready       TX byte stream out of the FIFO
//   halt, exit_code                sticky stop flag and the value written to TOHOST
//   bus_err                        combinational flag for an access to an unmapped address
module dmem_mmio #(
    parameter int RAM_WORDS  = 4096,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    input  logic        dmem_we,
    input  logic        dmem_re,
    output logic [31:0] dmem_rdata,
    output logic        uart_tx_valid,
    output logic [7:0]  uart_tx_data,
    input  logic        uart_tx_ready,
    output logic        halt,
    output logic [31:0] exit_code,
    output logic        bus_err
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   ram_mem [RAM_WORDS];
    logic [7:0]    fifo_mem [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   cycle_q, cycle_d;
    logic          halt_q, halt_d;
    logic [31:0]   exit_code_q, exit_code_d;

    // Decode on the word address; the byte offset never matters.
    logic [29:0]   word_addr;
    logic [AW-1:0] ram_idx;
    logic          sel_ram, sel_tx, sel_status, sel_cycle, sel_tohost, unmapped;
    logic          unused_addr_lsbs;

    assign word_addr        = dmem_addr[31:2];
    assign ram_idx          = dmem_addr[AW+1:2];
    assign unused_addr_lsbs = ^dmem_addr[1:0];
    assign sel_ram          = (word_addr < 30'(RAM_WORDS));
    assign sel_tx           = (word_addr == 30'h2000_0000);
    assign sel_status       = (word_addr == 30'h2000_0001);
    assign sel_cycle        = (word_addr == 30'h2000_0002);
    assign sel_tohost       = (word_addr == 30'h2000_0003);
    assign unmapped         = ~(sel_ram | sel_tx | sel_status | sel_cycle | sel_tohost);
    assign bus_err          = (dmem_we | dmem_re) & unmapped;

    logic fifo_empty, fifo_full, pop, push_req, push_ok, ovf_set, ovf_clr;
    logic tohost_wr, ram_we;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign pop        = ~fifo_empty & uart_tx_ready;
    assign push_req   = dmem_we & sel_tx & dmem_wstrb[0] & ~halt_q;
    // A full FIFO still accepts a byte when the head leaves in the same cycle;
    // the write lands in the slot being vacated (wr_ptr == rd_ptr when full).
    assign push_ok    = push_req & (~fifo_full | pop);
    assign ovf_set    = push_req & ~push_ok;
    assign ovf_clr    = dmem_we & sel_status & dmem_wdata[2];
    assign tohost_wr  = dmem_we & sel_tohost & ~halt_q;
    assign ram_we     = dmem_we & sel_ram;

    assign uart_tx_valid = ~fifo_empty;
    assign uart_tx_data  = fifo_mem[rd_ptr_q];
    assign halt          = halt_q;
    assign exit_code     = exit_code_q;

    logic [31:0] status_word;
    assign status_word = {23'd0, 5'(count_q), 1'b0, ovf_q, fifo_empty, fifo_full};

    // Zero-latency read path; pure function of address and current state.
    always_comb begin
        dmem_rdata = '0;
        if (sel_ram) begin
            dmem_rdata = ram_mem[ram_idx];
        end else if (sel_status) begin
            dmem_rdata = status_word;
        end else if (sel_cycle) begin
            dmem_rdata = cycle_q;
        end else if (sel_tohost) begin
            dmem_rdata = exit_code_q;
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        cycle_d     = cycle_q;
        halt_d      = halt_q;
        exit_code_d = exit_code_q;

        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Set beats clear when both happen together.
        if (ovf_set)      ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;

        if (!halt_q) cycle_d = cycle_q + 32'd1;

        if (tohost_wr) begin
            halt_d      = 1'b1;
            exit_code_d = dmem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            cycle_q     <= '0;
            halt_q      <= 1'b0;
            exit_code_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            cycle_q     <= cycle_d;
            halt_q      <= halt_d;
            exit_code_q <= exit_code_d;
        end
    end

    // RAM is never cleared by reset, and a write presented during reset is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (dmem_wstrb[b]) ram_mem[ram_idx][b*8 +: 8] <= dmem_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push_ok) fifo_mem[wr_ptr_q] <= dmem_wdata[7:0];
    end
endmodule

// File: tb/tb_dmem_mmio.sv
// tb/tb_dmem_mmio.sv - self-checking bench for dmem_mmio
module tb_dmem_mmio;
    localparam logic [31:0] A_TX     = 32'h8000_0000;
    localparam logic [31:0] A_STATUS = 32'h8000_0004;
    localparam logic [31:0] A_CYCLE  = 32'h8000_0008;
    localparam logic [31:0] A_TOHOST = 32'h8000_000C;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, exit_code;
    logic [3:0]  dmem_wstrb;
    logic        dmem_we, dmem_re;
    logic        uart_tx_valid, uart_tx_ready, halt, bus_err;
    logic [7:0]  uart_tx_data;

    int n_checks = 0;
    int n_errors = 0;

    dmem_mmio dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_wstrb    (dmem_wstrb),
        .dmem_we       (dmem_we),
        .dmem_re       (dmem_re),
        .dmem_rdata    (dmem_rdata),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_ready (uart_tx_ready),
        .halt          (halt),
        .exit_code     (exit_code),
        .bus_err       (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        chk_rd;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic re, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
        dmem_we    = we;
        dmem_re    = re;
        dmem_addr  = addr;
        dmem_wdata = wdata;
        dmem_wstrb = wstrb;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        drive(1'b0, 1'b1, addr, 32'h0, 4'h0);
        #1;
        check(name, dmem_rdata, exp);
        idle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        uart_tx_ready = 1'b0;
        idle();
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        check("rst_valid", {31'd0, uart_tx_valid}, 32'd0);
        check("rst_halt", {31'd0, halt}, 32'd0);
        check("rst_exit_code", exit_code, 32'd0);
        rd_check("rst_cycle", A_CYCLE, 32'd0);
        rd_check("rst_status", A_STATUS, 32'h002);
        tick();

        // RAM byte strobes, read-during-write, decode and unmapped accesses
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0100, 32'h1122_3344, 4'hF, 1'b0, 32'h0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0100, 32'hAABB_CCDD, 4'h4, 1'b1, 32'h1122_3344, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'h0, 1'b1, 32'h11BB_3344, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_0103, 32'h0, 4'h0, 1'b1, 32'h11BB_3344, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_0104, 32'h1234_5678, 4'h1, 1'b1, 32'hDEAD_BEEF, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_0104, 32'h0, 4'h0, 1'b1, 32'hDEAD_BE78, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_3FFC, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'h0000_3FFC, 32'h0, 4'h0, 1'b1, 32'hCAFE_F00D, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'h0000_4000, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 32'h4000_0000, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 32'h4000_0000, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 32'h4000_0000, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, A_STATUS, 32'h0, 4'h0, 1'b1, 32'h002, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'h0, 1'b1, 32'h11BB_3344, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 32'h8000_0010, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1};

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
            #1;
            if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), dmem_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_bus_err", i), {31'd0, bus_err}, {31'd0, vecs[i].exp_err});
            tick();
        end
        idle();

        // FIFO fill, overflow and in-order drain
        uart_tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b0, A_TX, 32'h41 + i, 4'h1);
            tick();
        end
        idle();
        rd_check("ovf_status", A_STATUS, 32'h085);
        check("ovf_head", {24'd0, uart_tx_data}, 32'h41);
        uart_tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("drain%0d_valid", i), {31'd0, uart_tx_valid}, 32'd1);
            check($sformatf("drain%0d_data", i), {24'd0, uart_tx_data}, 32'h41 + i);
            tick();
        end
        check("drain_done_valid", {31'd0, uart_tx_valid}, 32'd0);
        rd_check("drain_status", A_STATUS, 32'h006);
        tick();
        drive(1'b1, 1'b0, A_STATUS, 32'h4, 4'hF);
        tick();
        idle();
        rd_check("ovf_clr_status", A_STATUS, 32'h002);
        drive(1'b1, 1'b0, A_TX, 32'h99, 4'h2);
        tick();
        idle();
        rd_check("no_lane0_push", A_STATUS, 32'h002);
        tick();

        // Push and pop together while full
        uart_tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, A_TX, 32'h50 + i, 4'h1);
            tick();
        end
        drive(1'b1, 1'b0, A_TX, 32'h5A, 4'h1);
        uart_tx_ready = 1'b1;
        #1;
        check("fullpp_head", {24'd0, uart_tx_data}, 32'h50);
        tick();
        idle();
        uart_tx_ready = 1'b0;
        rd_check("fullpp_status", A_STATUS, 32'h081);
        uart_tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("fullpp%0d_data", i), {24'd0, uart_tx_data},
                  (i == 7) ? 32'h5A : 32'h51 + i);
            tick();
        end
        check("fullpp_done_valid", {31'd0, uart_tx_valid}, 32'd0);

        // Reset in the middle of a queue
        uart_tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, A_TX, 32'h61 + i, 4'h1);
            tick();
        end
        drive(1'b1, 1'b0, 32'h0000_0200, 32'h0BAD_F00D, 4'hF);
        tick();
        idle();
        check("preq_valid", {31'd0, uart_tx_valid}, 32'd1);
        drive(1'b1, 1'b0, A_TX, 32'h64, 4'h1);
        uart_tx_ready = 1'b1;
        do_reset();
        idle();
        uart_tx_ready = 1'b0;
        check("mid_rst_valid", {31'd0, uart_tx_valid}, 32'd0);
        rd_check("mid_rst_status", A_STATUS, 32'h002);
        rd_check("mid_rst_cycle", A_CYCLE, 32'd0);
        rd_check("mid_rst_ram", 32'h0000_0200, 32'h0BAD_F00D);
        tick();
        check("mid_rst_no_push", {31'd0, uart_tx_valid}, 32'd0);

        // Halt via TOHOST
        do_reset();
        idle();
        rd_check("halt_cyc0", A_CYCLE, 32'd0);
        for (int i = 0; i < 5; i++) tick();
        rd_check("halt_cycN", A_CYCLE, 32'd5);
        drive(1'b1, 1'b0, A_TOHOST, 32'h1, 4'hF);
        tick();
        idle();
        check("halt_set", {31'd0, halt}, 32'd1);
        check("halt_exit", exit_code, 32'd1);
        rd_check("halt_cyc_n1", A_CYCLE, 32'd6);
        for (int i = 0; i < 3; i++) tick();
        rd_check("halt_cyc_frozen", A_CYCLE, 32'd6);
        drive(1'b1, 1'b0, A_TOHOST, 32'h3, 4'hF);
        tick();
        idle();
        check("halt_exit_kept", exit_code, 32'd1);
        check("halt_sticky", {31'd0, halt}, 32'd1);
        drive(1'b1, 1'b0, A_TX, 32'h77, 4'h1);
        tick();
        idle();
        check("halt_no_push", {31'd0, uart_tx_valid}, 32'd0);
        drive(1'b1, 1'b0, 32'h0000_0300, 32'h5555_AAAA, 4'hF);
        tick();
        idle();
        rd_check("halt_ram_write", 32'h0000_0300, 32'h5555_AAAA);

        do_reset();
        idle();
        check("final_halt", {31'd0, halt}, 32'd0);
        check("final_exit", exit_code, 32'd0);
        rd_check("final_ram", 32'h0000_0300, 32'h5555_AAAA);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dmem_mmio.md
DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
REQ-001 The block SHALL have parameter RAM_WORDS, default 4096, meaning the number of 32-bit data RAM words (power of two).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, meaning the number of UART TX FIFO byte entries (power of two, 2..16).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port dmem_addr, input, 32 bits: byte address from the core LSU.
REQ-006 The block SHALL have port dmem_wdata, input, 32 bits: store data, already lane-aligned.
REQ-007 The block SHALL have port dmem_wstrb, input, 4 bits: byte write enables.
REQ-008 The block SHALL have ports dmem_we and dmem_re, inputs, 1 bit each: write and read request.
REQ-009 The block SHALL have port dmem_rdata, output, 32 bits: combinational read data.
REQ-010 The block SHALL have ports uart_tx_valid (output, 1), uart_tx_data (output, 8) and uart_tx_ready (input, 1): the TX byte stream.
REQ-011 The block SHALL have ports halt (output, 1) and exit_code (output, 32): the simulation stop flag and its value.
REQ-012 The block SHALL have port bus_err, output, 1 bit: combinational flag for an access to an unmapped address.

Function
REQ-013 Memory map:
- RAM: 0x0000_0000 .. RAM_WORDS*4-1.
- UART_TX: 0x8000_0000.
- UART_STATUS: 0x8000_0004.
- CYCLE: 0x8000_0008.
- TOHOST: 0x8000_000C.
- Any other address is unmapped.
REQ-014 Decode SHALL use dmem_addr[31:2]; dmem_addr[1:0] SHALL be ignored.
REQ-015 Reads SHALL be combinational with zero latency; dmem_rdata SHALL be valid in the same cycle as the address, independent of dmem_re.
REQ-016 Reads SHALL have no side effects.
REQ-017 A RAM write SHALL update, at the clock edge, only the bytes whose dmem_wstrb bit is 1 when dmem_we=1.
REQ-018 A read and a write to the same RAM word in the same cycle SHALL return the old data.
REQ-019 A write to UART_TX with dmem_wstrb[0]=1 SHALL push dmem_wdata[7:0] into the FIFO.
REQ-020 The push SHALL be accepted when count<FIFO_DEPTH, or when a pop occurs in the same cycle; otherwise the byte SHALL be dropped and the sticky overflow bit SHALL be set.
REQ-021 uart_tx_valid SHALL be 1 exactly when count>0, and uart_tx_data SHALL be the head entry.
REQ-022 A pop SHALL occur when uart_tx_valid and uart_tx_ready are both 1.
REQ-023 A push and pop in the same cycle SHALL leave count unchanged, and FIFO order SHALL be preserved.
REQ-024 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 UART_STATUS reads SHALL return: bit0 full, bit1 empty, bit2 overflow, bits[8:4] count, all other bits 0.
REQ-026 A write to UART_STATUS with wdata[2]=1 SHALL clear the overflow bit.
REQ-027 If an overflow set and an overflow clear occur in the same cycle, set SHALL win.
REQ-028 The CYCLE counter SHALL be 32 bits, increment by 1 every cycle while halt=0, wrap from 0xFFFF_FFFF to 0, and be read-only.
REQ-029 A write to TOHOST while halt=0 SHALL, at the edge, set halt=1 and exit_code=dmem_wdata.
REQ-030 halt SHALL be sticky; while halt=1, TOHOST and UART_TX writes SHALL be ignored and CYCLE SHALL freeze.
REQ-031 While halt=1, RAM writes and FIFO draining SHALL continue.
REQ-032 An unmapped access SHALL read as 0, and an unmapped write SHALL be ignored.
REQ-033 bus_err SHALL equal (dmem_we|dmem_re) & unmapped.

Reset
REQ-034 With rst_n=0 at an edge, the following SHALL all be set to 0: FIFO pointers and count, overflow, CYCLE, halt, exit_code.
REQ-035 Reset SHALL take priority over any write or pop in the same cycle.
REQ-036 Reset SHALL leave RAM contents unchanged.
REQ-037 After reset: uart_tx_valid=0, halt=0, exit_code=0.
REQ-038 Reset asserted mid-drain SHALL discard the pending bytes.

Verification
REQ-039 Byte-strobe RAM test: write 0x11223344 to 0x100 with wstrb=4'hF, then 0xAABBCCDD with wstrb=4'b0100 -> a read of 0x100 SHALL return 0x11BB3344.
REQ-040 FIFO full/overflow test, uart_tx_ready=0: push bytes 0x41..0x48, then 0x49 -> STATUS SHALL read 0x085; then uart_tx_ready=1 -> 0x41..0x48 SHALL drain in order, one per cycle, and 0x49 SHALL never appear.
REQ-041 Simultaneous push/pop at full: FIFO full, ready=1, push 0x5A -> count SHALL stay 8, overflow SHALL stay 0, and 0x5A SHALL exit last.
REQ-042 Halt test: write 0x0000_0001 to TOHOST at cycle N -> halt=1 and exit_code=1 from N+1, CYCLE SHALL freeze at N+1, and a later TOHOST write of 0x3 SHALL leave exit_code=1.
REQ-043 Unmapped access: read of 0x4000_0000 with dmem_re=1 -> dmem_rdata=0 and bus_err=1; a write there SHALL change no state.
REQ-044 Reset mid-operation: 3 bytes queued, rst_n=0 for one cycle -> the next cycle SHALL show uart_tx_valid=0, STATUS=0x002, CYCLE=0, and RAM contents preserved.
